// File: rtl/npc_pipe_pkg.sv
// Shared next-PC definitions: op encodings used by the D-stage controller, FSM states.
package npc_pipe_pkg;

  localparam int NPC_OP_W = 2;

  typedef enum logic [NPC_OP_W-1:0] {
    NPC_OP_PC4 = 2'd0,
    NPC_OP_BR  = 2'd1,
    NPC_OP_J   = 2'd2,
    NPC_OP_JR  = 2'd3
  } npc_op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } npc_state_e;

endpackage

// File: rtl/npc_pipe_if.sv
// D-stage control-flow bundle into the fetch PC; exception fields exist only with NPC_EXC_EN.
// master = D-stage side driving redirects, slave = npc_pipe.
interface npc_pipe_if
  import npc_pipe_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic                stall_f;
  logic                redir_valid;
  logic [NPC_OP_W-1:0] npc_op;
  logic                br_taken;
  logic [15:0]         br_imm;
  logic [25:0]         j_imm;
  logic [ADDR_W-1:0]   jr_target;
  logic [ADDR_W-1:0]   pc_d;
  logic [ADDR_W-1:0]   pc_f;
  logic [ADDR_W-1:0]   link_d;
  logic                redir_pending;
`ifdef NPC_EXC_EN
  logic                exc_req;
  logic                eret_req;
  logic [ADDR_W-1:0]   epc;
  logic                fetch_adel;
`endif

  modport master (
    output stall_f, redir_valid, npc_op, br_taken, br_imm, j_imm, jr_target, pc_d,
`ifdef NPC_EXC_EN
    output exc_req, eret_req, epc,
    input  fetch_adel,
`endif
    input  pc_f, link_d, redir_pending
  );

  modport slave (
    input  stall_f, redir_valid, npc_op, br_taken, br_imm, j_imm, jr_target, pc_d,
`ifdef NPC_EXC_EN
    input  exc_req, eret_req, epc,
    output fetch_adel,
`endif
    output pc_f, link_d, redir_pending
  );

endinterface

// File: rtl/npc_pipe_target.sv
// Redirect target from D-stage control flow; purely combinational, no state, no backpressure.
// tgt_vld is low for PC4 and for untaken branches.
module npc_target
  import npc_pipe_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [NPC_OP_W-1:0] npc_op,
  input  logic                br_taken,
  input  logic [15:0]         br_imm,
  input  logic [25:0]         j_imm,
  input  logic [ADDR_W-1:0]   jr_target,
  input  logic [ADDR_W-1:0]   pc_d,
  output logic [ADDR_W-1:0]   tgt,
  output logic                tgt_vld
);

  npc_op_e           op;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;

  assign op     = npc_op_e'(npc_op);
  assign br_off = {{(ADDR_W-18){br_imm[15]}}, br_imm, 2'b00};
  assign br_tgt = pc_d + ADDR_W'(4) + br_off;

  // The jump region comes from the D-stage PC, i.e. the branch itself, not the delay slot.
  generate
    if (ADDR_W > 28) begin : g_jregion
      assign j_tgt = {pc_d[ADDR_W-1:28], j_imm, 2'b00};
    end else begin : g_jflat
      assign j_tgt = {j_imm, 2'b00};
    end
  endgenerate

  always_comb begin
    tgt     = '0;
    tgt_vld = 1'b0;
    case (op)
      NPC_OP_BR: begin
        tgt     = br_tgt;
        tgt_vld = br_taken;
      end
      NPC_OP_J: begin
        tgt     = j_tgt;
        tgt_vld = 1'b1;
      end
      NPC_OP_JR: begin
        tgt     = jr_target;
        tgt_vld = 1'b1;
      end
      default: begin
        tgt     = '0;
        tgt_vld = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/npc_pipe.sv
// Fetch PC register with next-PC select; redirect latency 1 cycle, stalled redirects held until stall_f drops.
// Optional exception/eret entry under NPC_EXC_EN (overrides stall_f).
module npc_pipe
  import npc_pipe_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
`ifdef NPC_EXC_EN
  ,
  parameter logic [ADDR_W-1:0] EXC_VEC  = 32'h0000_4180
`endif
) (
  input logic       clk,
  input logic       reset,
  npc_pipe_if.slave bus
);

  npc_state_e        state;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] cap_q;
  logic [ADDR_W-1:0] tgt;
  logic              tgt_vld;
  logic              redir;

  npc_target #(.ADDR_W(ADDR_W)) u_target (
    .npc_op    (bus.npc_op),
    .br_taken  (bus.br_taken),
    .br_imm    (bus.br_imm),
    .j_imm     (bus.j_imm),
    .jr_target (bus.jr_target),
    .pc_d      (bus.pc_d),
    .tgt       (tgt),
    .tgt_vld   (tgt_vld)
  );

  assign redir = bus.redir_valid & tgt_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      pc_q  <= RESET_PC;
      cap_q <= '0;
    end
`ifdef NPC_EXC_EN
    else if (bus.exc_req) begin
      state <= ST_RUN;
      pc_q  <= EXC_VEC;
    end else if (bus.eret_req) begin
      state <= ST_RUN;
      pc_q  <= bus.epc;
    end
`endif
    else begin
      case (state)
        ST_RUN: begin
          if (redir) begin
            if (bus.stall_f) begin
              cap_q <= tgt;
              state <= ST_PEND;
            end else begin
              pc_q <= tgt;
            end
          end else if (!bus.stall_f) begin
            pc_q <= pc_q + ADDR_W'(4);
          end
        end
        ST_PEND: begin
          // Last redirect wins; a fresh one on the release cycle bypasses the capture.
          if (bus.stall_f) begin
            if (redir) cap_q <= tgt;
          end else begin
            pc_q  <= redir ? tgt : cap_q;
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.pc_f          = pc_q;
  assign bus.redir_pending = (state == ST_PEND);
  assign bus.link_d        = bus.pc_d + ADDR_W'(8);
`ifdef NPC_EXC_EN
  assign bus.fetch_adel    = (pc_q[1:0] != 2'b00);
`endif

endmodule

// File: tb/tb_npc_pipe.sv
// Randomized + directed bench for npc_pipe against a queue-based next-PC model.
module tb_npc_pipe;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;
  logic chk_en;

  npc_pipe_if #(.ADDR_W(32)) bus ();

  npc_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Model: fetch PC plus a one-deep queue of waiting redirect targets.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic [32:0] m_t;

  function automatic logic [32:0] target_of(input logic [1:0] op, input logic taken,
                                            input logic [15:0] bi, input logic [25:0] ji,
                                            input logic [31:0] jr, input logic [31:0] pcd);
    logic [31:0] off;
    off = {{16{bi[15]}}, bi};
    case (op)
      2'd1:    return {taken, pcd + 32'd4 + off * 32'd4};
      2'd2:    return {1'b1, pcd[31:28], ji, 2'b00};
      2'd3:    return {1'b1, jr};
      default: return 33'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 32'h0000_3000;
      m_q.delete();
    end
`ifdef NPC_EXC_EN
    else if (bus.exc_req) begin
      m_pc = 32'h0000_4180;
      m_q.delete();
    end else if (bus.eret_req) begin
      m_pc = bus.epc;
      m_q.delete();
    end
`endif
    else begin
      m_t = target_of(bus.npc_op, bus.br_taken, bus.br_imm, bus.j_imm, bus.jr_target, bus.pc_d);
      if (!bus.redir_valid) m_t[32] = 1'b0;
      if (!bus.stall_f) begin
        if (m_t[32]) m_pc = m_t[31:0];
        else if (m_q.size() != 0) m_pc = m_q[0];
        else m_pc = m_pc + 32'd4;
        m_q.delete();
      end else if (m_t[32]) begin
        m_q.delete();
        m_q.push_back(m_t[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_f", bus.pc_f, m_pc);
      chk("redir_pending", {31'd0, bus.redir_pending}, {31'd0, m_q.size() != 0});
      chk("link_d", bus.link_d, bus.pc_d + 32'd8);
`ifdef NPC_EXC_EN
      chk("fetch_adel", {31'd0, bus.fetch_adel}, {31'd0, m_pc[1:0] != 2'b00});
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.stall_f     = 1'b0;
    bus.redir_valid = 1'b0;
    bus.npc_op      = 2'd0;
    bus.br_taken    = 1'b0;
    bus.br_imm      = 16'd0;
    bus.j_imm       = 26'd0;
    bus.jr_target   = 32'd0;
    bus.pc_d        = 32'd0;
`ifdef NPC_EXC_EN
    bus.exc_req     = 1'b0;
    bus.eret_req    = 1'b0;
    bus.epc         = 32'd0;
`endif
  endtask

  task automatic reset_adv(input int n);
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    repeat (n) tick();
  endtask

  task automatic redir(input logic [1:0] op, input logic taken, input logic [15:0] bi,
                       input logic [25:0] ji, input logic [31:0] jr, input logic [31:0] pcd);
    bus.redir_valid = 1'b1;
    bus.npc_op      = op;
    bus.br_taken    = taken;
    bus.br_imm      = bi;
    bus.j_imm       = ji;
    bus.jr_target   = jr;
    bus.pc_d        = pcd;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    chk_en = 1'b0;
    reset  = 1'b1;
    idle();
    tick();
    chk_en = 1'b1;

    // Reset value and sequential fetch.
    chk("reset pc_f", bus.pc_f, 32'h3000);
    chk("reset pending", {31'd0, bus.redir_pending}, 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq pc_f", bus.pc_f, 32'h3000 + 32'(4 * i));
    end

    // Backward branch to itself, then the same branch not taken.
    reset_adv(2);
    redir(2'd1, 1'b1, 16'hFFFF, 26'd0, 32'd0, 32'h3004);
    tick();
    chk("br taken", bus.pc_f, 32'h3004);
    reset_adv(2);
    redir(2'd1, 1'b0, 16'hFFFF, 26'd0, 32'd0, 32'h3004);
    tick();
    chk("br not taken", bus.pc_f, 32'h300C);

    // Jump arriving under a 3-cycle stall.
    reset_adv(5);
    redir(2'd2, 1'b0, 16'd0, 26'h0000C40, 32'd0, 32'h3010);
    bus.stall_f = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.redir_valid = 1'b0;
      chk("j stalled pc_f", bus.pc_f, 32'h3014);
      chk("j stalled pending", {31'd0, bus.redir_pending}, 32'd1);
    end
    bus.stall_f = 1'b0;
    tick();
    chk("j release pc_f", bus.pc_f, 32'h3100);
    chk("j release pending", {31'd0, bus.redir_pending}, 32'd0);

    // A later JR overwrites the captured jump.
    reset_adv(5);
    redir(2'd2, 1'b0, 16'd0, 26'h0000C40, 32'd0, 32'h3010);
    bus.stall_f = 1'b1;
    tick();
    redir(2'd3, 1'b0, 16'd0, 26'd0, 32'h3FFC, 32'h3014);
    tick();
    bus.redir_valid = 1'b0;
    bus.stall_f     = 1'b0;
    tick();
    chk("jr overwrite", bus.pc_f, 32'h3FFC);

    // Reset while pending discards the capture.
    reset_adv(5);
    redir(2'd2, 1'b0, 16'd0, 26'h0000C40, 32'd0, 32'h3010);
    bus.stall_f = 1'b1;
    tick();
    bus.redir_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("reset mid-pend pc_f", bus.pc_f, 32'h3000);
    chk("reset mid-pend pending", {31'd0, bus.redir_pending}, 32'd0);
    reset = 1'b0;
    bus.stall_f = 1'b0;
    tick();
    chk("after reset release", bus.pc_f, 32'h3004);

    // Target arithmetic wraps.
    reset_adv(0);
    redir(2'd1, 1'b1, 16'h0002, 26'd0, 32'd0, 32'hFFFF_FFF8);
    tick();
    chk("wrap", bus.pc_f, 32'h0000_0004);
    chk("wrap link_d", bus.link_d, 32'h0000_0000);

`ifdef NPC_EXC_EN
    reset_adv(1);
    redir(2'd3, 1'b0, 16'd0, 26'd0, 32'h3FFC, 32'h3000);
    bus.stall_f = 1'b1;
    bus.exc_req = 1'b1;
    tick();
    chk("exc pc_f", bus.pc_f, 32'h4180);
    chk("exc pending", {31'd0, bus.redir_pending}, 32'd0);
    idle();
    bus.eret_req = 1'b1;
    bus.epc      = 32'h3020;
    tick();
    chk("eret pc_f", bus.pc_f, 32'h3020);
    idle();
    redir(2'd3, 1'b0, 16'd0, 26'd0, 32'h3002, 32'h301C);
    tick();
    chk("adel pc_f", bus.pc_f, 32'h3002);
    chk("adel flag", {31'd0, bus.fetch_adel}, 32'd1);
`endif

    // Random traffic, checked every cycle by the compare process.
    reset_adv(0);
    for (int i = 0; i < 1500; i++) begin
      reset           = ($urandom_range(99) == 0);
      bus.stall_f     = ($urandom_range(9) < 3);
      bus.redir_valid = ($urandom_range(9) < 4);
      bus.npc_op      = 2'($urandom_range(3));
      bus.br_taken    = 1'($urandom_range(1));
      bus.br_imm      = 16'($urandom);
      bus.j_imm       = 26'($urandom);
      bus.jr_target   = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      bus.pc_d        = ($urandom_range(3) != 0) ? (m_pc - 32'd4) : $urandom;
`ifdef NPC_EXC_EN
      bus.exc_req     = ($urandom_range(99) < 3);
      bus.eret_req    = ($urandom_range(99) < 3);
      bus.epc         = $urandom;
`endif
      tick();
    end
    reset = 1'b0;
    idle();
    tick();
    @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
